// File: rtl/uart_io_ctrl.sv
// Byte I/O sequencer between the core and uart_tx/uart_rx: TX FIFO + drain FSM, RX FIFO, sticky status.
// Optional input loopback (TX bytes routed into RX FIFO) enabled by defining UART_IO_LOOPBACK_EN.
module uart_io_ctrl #(
   parameter int TX_AW = 2,
   parameter int RX_AW = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             out_req,
   input  logic [7:0]       out_data,
   output logic             out_ready,
   input  logic             in_req,
   output logic             in_valid,
   output logic [7:0]       in_data,
   output logic [7:0]       tx_data,
   output logic             tx_start,
   input  logic             tx_busy,
   input  logic [7:0]       rx_data,
   input  logic             rx_ready,
   input  logic             rx_ferr,
`ifdef UART_IO_LOOPBACK_EN
   input  logic             loopback,
`endif
   input  logic             clr_status,
   output logic             rx_overflow,
   output logic             rx_frame_err,
   output logic             tx_empty,
   output logic [RX_AW:0]   rx_count
);

   localparam int TX_DEPTH = 1 << TX_AW;
   localparam int RX_DEPTH = 1 << RX_AW;
   localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(1) << TX_AW;
   localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(1) << RX_AW;

   typedef enum logic [1:0] {
      T_IDLE,
      T_START,
      T_WAITHI,
      T_WAITLO
   } t_state_e;

   t_state_e state, state_d;

   // ---------------- TX FIFO ----------------
   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr, tx_rd;
   logic [TX_AW:0]   tx_cnt;
   logic             tx_push, tx_pop;
   logic [1:0]       wd_cnt;
   logic [7:0]       tx_data_q;

   assign out_ready = (tx_cnt != TX_FULL);
   assign tx_push   = out_req && out_ready;
   assign tx_pop    = (state == T_START);
   assign tx_empty  = (tx_cnt == '0) && (state == T_IDLE);
   assign tx_data   = tx_data_q;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr] <= out_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_wr  <= '0;
         tx_rd  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + 1'b1;
         if (tx_pop)  tx_rd <= tx_rd + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + 1'b1;
            2'b01:   tx_cnt <= tx_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- TX drain FSM ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= T_IDLE;
         wd_cnt    <= '0;
         tx_data_q <= '0;
      end else begin
         state <= state_d;
         if (state == T_WAITHI) wd_cnt <= wd_cnt + 1'b1;
         else                   wd_cnt <= '0;
         // head is latched on entry so tx_data is already valid while tx_start is high
         if (state == T_IDLE && state_d == T_START) tx_data_q <= tx_mem[tx_rd];
      end
   end

   always_comb begin
      state_d  = state;
      tx_start = 1'b0;
      case (state)
         T_IDLE: begin
            if (tx_cnt != '0 && !tx_busy) state_d = T_START;
         end
         T_START: begin
`ifdef UART_IO_LOOPBACK_EN
            tx_start = !loopback;
            state_d  = loopback ? T_IDLE : T_WAITHI;
`else
            tx_start = 1'b1;
            state_d  = T_WAITHI;
`endif
         end
         T_WAITHI: begin
            if (tx_busy || wd_cnt == 2'd3) state_d = T_WAITLO;
         end
         T_WAITLO: begin
            if (!tx_busy) state_d = T_IDLE;
         end
         default: state_d = T_IDLE;
      endcase
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]       rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr, rx_rd;
   logic [RX_AW:0]   rx_cnt;
   logic             wr_req, wr_ferr, rx_pop, rx_push, rx_full;
   logic [7:0]       wr_dat;

`ifdef UART_IO_LOOPBACK_EN
   assign wr_req  = loopback ? (state == T_START) : rx_ready;
   assign wr_dat  = loopback ? tx_data_q : rx_data;
   assign wr_ferr = loopback ? 1'b0 : rx_ferr;
`else
   assign wr_req  = rx_ready;
   assign wr_dat  = rx_data;
   assign wr_ferr = rx_ferr;
`endif

   assign rx_full  = (rx_cnt == RX_FULL);
   assign rx_pop   = in_req && (rx_cnt != '0) && !in_valid;
   assign rx_push  = wr_req && !wr_ferr && (!rx_full || rx_pop);
   assign rx_count = rx_cnt;

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_wr        <= '0;
         rx_rd        <= '0;
         rx_cnt       <= '0;
         in_valid     <= 1'b0;
         in_data      <= '0;
         rx_overflow  <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         if (rx_push) rx_wr <= rx_wr + 1'b1;
         if (rx_pop) begin
            rx_rd   <= rx_rd + 1'b1;
            in_data <= rx_mem[rx_rd];
         end
         in_valid <= rx_pop;
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + 1'b1;
            2'b01:   rx_cnt <= rx_cnt - 1'b1;
            default: ;
         endcase
         // a set event in the clearing cycle wins
         rx_overflow  <= (wr_req && !wr_ferr && rx_full && !rx_pop) || (rx_overflow && !clr_status);
         rx_frame_err <= (wr_req && wr_ferr) || (rx_frame_err && !clr_status);
      end
   end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Self-checking bench for uart_io_ctrl: vector table for TX fill, scoreboards for TX and RX bytes.
module tb_uart_io_ctrl;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       out_req = 1'b0;
   logic [7:0] out_data = '0;
   logic       out_ready;
   logic       in_req = 1'b0;
   logic       in_valid;
   logic [7:0] in_data;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_ready = 1'b0;
   logic       rx_ferr = 1'b0;
   logic       clr_status = 1'b0;
   logic       rx_overflow;
   logic       rx_frame_err;
   logic       tx_empty;
   logic [4:0] rx_count;

   always #5 clk = ~clk;

   uart_io_ctrl #(.TX_AW(2), .RX_AW(4)) dut (
      .clk(clk), .rstn(rstn),
      .out_req(out_req), .out_data(out_data), .out_ready(out_ready),
      .in_req(in_req), .in_valid(in_valid), .in_data(in_data),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .rx_data(rx_data), .rx_ready(rx_ready), .rx_ferr(rx_ferr),
`ifdef UART_IO_LOOPBACK_EN
      .loopback(1'b0),
`endif
      .clr_status(clr_status), .rx_overflow(rx_overflow),
      .rx_frame_err(rx_frame_err), .tx_empty(tx_empty), .rx_count(rx_count)
   );

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   logic [7:0] txq[$];
   logic [7:0] rxq[$];

   // uart_tx model: busy for 5 cycles after each start unless disabled
   logic hold_busy = 1'b0;
   logic no_busy = 1'b0;
   int   busy_cnt = 0;
   int   tx_starts = 0;
   int   cyc = 0;
   int   last_start = -1;
   int   last_gap = 0;

   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (tx_start === 1'b1) begin
            check("tx_start_busy_low", tx_busy, 0);
            if (last_start >= 0) begin
               last_gap = cyc - last_start;
               check("tx_start_spacing", last_gap >= 4, 1);
            end
            last_start = cyc;
            check("tx_start_expected", txq.size() != 0, 1);
            if (txq.size() != 0) begin
               e = txq.pop_front();
               check("tx_data", tx_data, e);
            end
            tx_starts++;
            if (!no_busy) busy_cnt = 5;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end
         tx_busy = hold_busy || (busy_cnt > 0);
      end
   end

   // RX output monitor
   logic prev_iv = 1'b0;
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (in_valid === 1'b1) begin
            check("in_valid_not_consecutive", prev_iv, 0);
            check("in_valid_expected", rxq.size() != 0, 1);
            if (rxq.size() != 0) begin
               e = rxq.pop_front();
               check("in_data", in_data, e);
            end
         end
         prev_iv = in_valid;
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   task automatic rx_byte(input logic [7:0] d, input logic ferr);
      rx_ready = 1'b1;
      rx_data  = d;
      rx_ferr  = ferr;
      @(negedge clk);
      rx_ready = 1'b0;
      rx_ferr  = 1'b0;
   endtask

   task automatic wait_starts(input int target, input int budget, input string name);
      int k = 0;
      while (tx_starts < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, tx_starts >= target, 1);
   endtask

   task automatic read_n(input int n, input int budget, input string name);
      int got = 0;
      int k = 0;
      in_req = 1'b1;
      while (got < n && k < budget) begin
         @(negedge clk);
         if (in_valid === 1'b1) got++;
         k++;
      end
      in_req = 1'b0;
      check(name, got, n);
   endtask

   typedef struct {
      logic       req;
      logic [7:0] data;
      logic       exp_ready;
      logic       exp_empty;
   } tx_vec_t;

   tx_vec_t tx_tab [5];

   initial begin
      int n0, m, k;
      logic bad;

      tx_tab[0] = '{1'b1, 8'h41, 1'b1, 1'b0};
      tx_tab[1] = '{1'b1, 8'h42, 1'b1, 1'b0};
      tx_tab[2] = '{1'b1, 8'h43, 1'b1, 1'b0};
      tx_tab[3] = '{1'b1, 8'h44, 1'b0, 1'b0};
      tx_tab[4] = '{1'b1, 8'h45, 1'b0, 1'b0};

      #2 rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_in_valid", in_valid, 0);
      check("rst_in_data", in_data, 0);
      check("rst_overflow", rx_overflow, 0);
      check("rst_frame_err", rx_frame_err, 0);
      check("rst_tx_empty", tx_empty, 1);
      check("rst_out_ready", out_ready, 1);
      check("rst_rx_count", rx_count, 0);
      rstn = 1'b1;
      @(negedge clk);

      // reset during T_WAITLO
      txq.push_back(8'h41);
      out_req = 1'b1; out_data = 8'h41;
      @(negedge clk);
      out_req = 1'b0;
      wait_starts(1, 20, "mid_drain_start_seen");
      repeat (3) @(negedge clk);
      check("mid_drain_busy_phase_not_empty", tx_empty, 0);
      rstn = 1'b0;
      #1;
      check("mid_rst_tx_start", tx_start, 0);
      check("mid_rst_tx_data", tx_data, 0);
      check("mid_rst_tx_empty", tx_empty, 1);
      check("mid_rst_out_ready", out_ready, 1);
      @(negedge clk);
      rstn = 1'b1;
      n0 = tx_starts;
      repeat (20) @(negedge clk);
      check("no_start_after_reset", tx_starts, n0);

      // TX fill while uart_tx is busy, then drain
      hold_busy = 1'b1;
      repeat (2) @(negedge clk);
      m = 0;
      n0 = tx_starts;
      for (int i = 0; i < 5; i++) begin
         out_req  = tx_tab[i].req;
         out_data = tx_tab[i].data;
         if (m < 4) begin
            txq.push_back(tx_tab[i].data);
            m++;
         end
         @(negedge clk);
         check("fill_out_ready", out_ready, tx_tab[i].exp_ready);
         check("fill_tx_empty", tx_empty, tx_tab[i].exp_empty);
      end
      out_req = 1'b0;
      hold_busy = 1'b0;
      wait_starts(n0 + 4, 200, "drain_four_starts");
      k = 0;
      while (tx_busy && k < 20) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      check("drain_tx_empty", tx_empty, 1);
      check("drain_out_ready", out_ready, 1);
      check("drain_no_fifth", tx_starts - n0, 4);

      // missed busy edge: watchdog must still release the FSM
      no_busy = 1'b1;
      n0 = tx_starts;
      txq.push_back(8'h61); txq.push_back(8'h62);
      out_req = 1'b1; out_data = 8'h61;
      @(negedge clk);
      out_data = 8'h62;
      @(negedge clk);
      out_req = 1'b0;
      wait_starts(n0 + 2, 60, "watchdog_two_starts");
      check("watchdog_gap_range", (last_gap >= 5) && (last_gap <= 8), 1);
      repeat (10) @(negedge clk);
      check("watchdog_tx_empty", tx_empty, 1);
      no_busy = 1'b0;

      // RX latency
      rxq.push_back(8'h5A);
      rx_byte(8'h5A, 1'b0);
      check("lat_count_one", rx_count, 1);
      in_req = 1'b1;
      @(negedge clk);
      check("lat_in_valid", in_valid, 1);
      in_req = 1'b0;
      @(negedge clk);
      check("lat_count_zero", rx_count, 0);
      check("lat_in_valid_drop", in_valid, 0);

      // RX overflow
      for (int i = 0; i < 17; i++) begin
         if (i < 16) rxq.push_back(8'(i));
         rx_byte(8'(i), 1'b0);
         if (i == 15) check("ovf_not_yet", rx_overflow, 0);
      end
      check("ovf_flag", rx_overflow, 1);
      check("ovf_count", rx_count, 16);
      read_n(16, 100, "ovf_reads");
      @(negedge clk);
      check("ovf_count_after_read", rx_count, 0);
      check("ovf_sticky", rx_overflow, 1);
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      check("ovf_cleared", rx_overflow, 0);

      // framing error, and set-beats-clear
      rx_byte(8'h77, 1'b1);
      check("ferr_flag", rx_frame_err, 1);
      check("ferr_not_stored", rx_count, 0);
      check("ferr_no_ovf", rx_overflow, 0);
      clr_status = 1'b1;
      rx_byte(8'h78, 1'b1);
      clr_status = 1'b0;
      check("ferr_set_wins", rx_frame_err, 1);
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      check("ferr_cleared", rx_frame_err, 0);

      // push into full FIFO in the same cycle as a pop
      for (int i = 0; i < 16; i++) begin
         rxq.push_back(8'h80 + 8'(i));
         rx_byte(8'h80 + 8'(i), 1'b0);
      end
      check("simul_full", rx_count, 16);
      rxq.push_back(8'h90);
      in_req = 1'b1;
      rx_ready = 1'b1; rx_data = 8'h90;
      @(negedge clk);
      rx_ready = 1'b0;
      in_req = 1'b0;
      check("simul_in_valid", in_valid, 1);
      check("simul_count", rx_count, 16);
      check("simul_no_ovf", rx_overflow, 0);
      read_n(16, 100, "simul_drain");
      @(negedge clk);
      check("simul_drained", rx_count, 0);

      // held in_req on empty FIFO
      in_req = 1'b1;
      bad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (in_valid !== 1'b0) bad = 1'b1;
      end
      check("held_empty_no_valid", bad, 0);
      rxq.push_back(8'h3C);
      rx_ready = 1'b1; rx_data = 8'h3C;
      @(negedge clk);
      rx_ready = 1'b0;
      check("held_no_bypass", in_valid, 0);
      @(negedge clk);
      check("held_valid", in_valid, 1);
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (in_valid !== 1'b0) bad = 1'b1;
      end
      in_req = 1'b0;
      check("held_single_valid", bad, 0);

      repeat (2) @(negedge clk);
      check("rx_scoreboard_empty", rxq.size(), 0);
      check("tx_scoreboard_empty", txq.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/uart_io_ctrl.md
Name: uart_io_ctrl

Overview:
- Sequences byte I/O between the multi-cycle core and the uart_tx / uart_rx pair.
- Buffers outgoing bytes in a TX FIFO and drains them to uart_tx one at a time through a start/busy handshake.
- Captures every received byte into an RX FIFO, so input arriving while the core is busy is not lost.
- Replaces the core's direct tx_busy / rx_ready polling with a request/valid interface, and reports sticky overflow and framing-error status.

Parameters:
- TX_AW, 2: log2 of TX FIFO depth (depth 4).
- RX_AW, 4: log2 of RX FIFO depth (depth 16).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- out_req  input  1  core pushes out_data this cycle
- out_data  input  8  byte to transmit
- out_ready  output  1  TX FIFO not full (combinational)
- in_req  input  1  core requests one received byte (level, held until in_valid)
- in_valid  output  1  one-cycle pulse; in_data valid
- in_data  output  8  popped RX byte
- tx_data  output  8  byte to uart_tx
- tx_start  output  1  one-cycle start strobe to uart_tx
- tx_busy  input  1  uart_tx busy
- rx_data  input  8  byte from uart_rx
- rx_ready  input  1  one-cycle pulse from uart_rx, rx_data valid
- rx_ferr  input  1  framing error qualifier for rx_ready
- clr_status  input  1  clears sticky flags
- rx_overflow  output  1  sticky: RX byte dropped because FIFO full
- rx_frame_err  output  1  sticky: byte dropped because of framing error
- tx_empty  output  1  TX FIFO empty and drain FSM idle
- rx_count  output  RX_AW+1  RX FIFO occupancy

Behaviour:
- Reset (rstn low, asynchronous): both FIFOs empty; pointers and counts 0; FSM in T_IDLE.
  - Outputs: tx_start=0, tx_data=0, in_valid=0, in_data=0, sticky flags 0, tx_empty=1, out_ready=1, rx_count=0.
  - Reset mid-transfer aborts the transfer and discards all FIFO contents.
- TX push: on out_req && out_ready, write out_data and increment count.
  - out_req while full is ignored; the byte is lost and no flag is set, so the core must check out_ready.
- TX drain FSM:
  - T_IDLE: FIFO non-empty and tx_busy=0 → T_START.
  - T_START: tx_data = FIFO head; tx_start=1 for exactly one cycle; pop head → T_WAITHI.
  - T_WAITHI: wait for tx_busy=1 → T_WAITLO. If tx_busy is not seen within 4 cycles → T_WAITLO anyway (guard against a missed busy edge).
  - T_WAITLO: wait for tx_busy=0 → T_IDLE.
  - Minimum spacing between tx_start pulses is 4 cycles.
  - tx_data holds its value from T_START until the next T_START.
- RX push: on rx_ready:
  - rx_ferr=1: byte dropped; rx_frame_err set.
  - Else if FIFO full and no pop this cycle: byte dropped; rx_overflow set.
  - Else: byte written.
- RX pop: when in_req=1, FIFO non-empty, and in_valid=0 last cycle, pop the head.
  - in_data and in_valid are registered and appear the next cycle (latency 1 from in_req to in_valid when data is present).
  - in_req held with the FIFO empty waits indefinitely; in_valid fires one cycle after the first byte lands (byte written at edge N, in_valid high after edge N+1).
  - Back-to-back: in_req held high yields in_valid at most every other cycle. in_valid is never high two consecutive cycles, which protects a core that drops in_req one cycle late.
- Simultaneous push and pop on RX:
  - Occupancy unchanged.
  - A full FIFO with a simultaneous pop accepts the push.
  - An empty FIFO with a simultaneous push does not pop (no bypass); the pop happens the next cycle.
- Pointers wrap modulo depth; count is RX_AW+1 bits, range 0..2^RX_AW.
- Sticky flags: clr_status clears both. A set event in the same cycle as clr_status wins (flag ends at 1).
- tx_empty = (TX count==0) && state==T_IDLE.

Optional Feature:
- Macro UART_IO_LOOPBACK_EN.
- When defined, adds input loopback (1 bit). While loopback=1:
  - Bytes popped by the drain FSM are written into the RX FIFO at T_START instead of raising tx_start; tx_start stays 0 and the FSM returns to T_IDLE.
  - uart_rx pushes are ignored.
  - Loopback writes obey the same full/overflow rule.
- When undefined: no loopback port, and the logic is absent.

Test Plan:
- Reset mid-drain: push 0x41, assert rstn low during T_WAITLO → all outputs at reset values immediately; no further tx_start after release.
- TX order/fill:
  - Push 0x41,0x42,0x43,0x44 on consecutive cycles → out_ready=0 after the 4th.
  - A 5th out_req while full is dropped.
  - tx_start pulses carry 0x41..0x44 in order, each pulse only after tx_busy falls.
  - tx_empty=1 after the last busy falls.
- RX latency: rx_ready with 0x5A, then in_req → in_valid one cycle later with in_data=0x5A; rx_count returns 0.
- RX overflow:
  - 17 rx_ready pulses (0x00..0x10) with no reads → rx_overflow=1 and rx_count=16.
  - Reads return 0x00..0x0F.
  - clr_status clears the flag.
- Framing/simultaneous: rx_ready with rx_ferr=1 → byte not stored, rx_frame_err=1. rx_ready on a full FIFO in the same cycle as a pop → accepted, no overflow, count stays 16.
- Held in_req on an empty FIFO, byte arrives (written at edge N) → single in_valid after edge N+1; in_valid never high two consecutive cycles.
